// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 front end.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, instr} with synchronous flush.
// Latency: a push becomes the head on the following cycle; the head is read combinationally.
// Backpressure: none internally; the producer must only push when a slot is free or a pop happens the same cycle.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, issues in-order word fetches and buffers returned words for decode.
// Latency: request accepted in cycle N, response in N+k, instruction visible to decode in N+k+1.
// Backpressure: halt holds the head; requests stop once in-flight plus buffered words reach QUEUE_DEPTH.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instruction_out,
  output logic [XLEN-1:0] pc_out
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_nxt;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  logic            req_fire;
  logic            drop_rsp;
  fetch_entry_t    q_head;
  fetch_entry_t    q_din;

  assign target_pc = word_align(redirect_pc);

  // Credit check counts buffered words too, so every response always has a slot.
  assign imem_req_valid = (state == FETCH) && !redirect_valid &&
                          ((int'(inflight) + int'(q_count)) < QUEUE_DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inflight_nxt = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
  assign drop_rsp     = imem_rsp_valid && (drop_cnt != '0);
  assign drop_nxt     = drop_cnt - CW'(drop_rsp);

  assign q_push = imem_rsp_valid && !drop_rsp && !redirect_valid;
  assign q_din  = '{pc: rsp_pc, instr: imem_rsp_data};

  assign instr_valid     = !q_empty && (state != BOOT);
  assign q_pop           = instr_valid && !halt;
  assign instruction_out = instr_valid ? q_head.instr : NOP_INSTR;
  assign pc_out          = instr_valid ? q_head.pc : '0;

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .din   (q_din),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the wrong path.
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        drop_cnt <= inflight_nxt;
        case (state)
          FETCH:   state <= (inflight_nxt != '0) ? DRAIN : FETCH;
          DRAIN:   state <= DRAIN;
          default: state <= FETCH;
        endcase
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (q_push)   rsp_pc   <= rsp_pc + XLEN'(4);
        drop_cnt <= drop_nxt;
        case (state)
          BOOT:    state <= FETCH;
          DRAIN:   if (drop_nxt == '0) state <= FETCH;
          default: state <= state;
        endcase
      end
    end
  end

  rsp_has_slot_a: assert property (@(posedge clk) disable iff (rst)
    q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import core_pkg::*;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt, redirect_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] redirect_pc, imem_rsp_data;
  logic        imem_req_valid, instr_valid;
  logic [31:0] imem_req_addr, instruction_out, pc_out;

  logic        halt2, redir2, ready2, rsp2_valid;
  logic [31:0] redir_pc2, rsp2_data;
  logic        req2_valid, iv2;
  logic [31:0] req2_addr, ins2, pc2;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instruction_out(instruction_out), .pc_out(pc_out));

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(D)) dut_wrap (
    .clk(clk), .rst(rst), .halt(halt2), .redirect_valid(redir2), .redirect_pc(redir_pc2),
    .imem_req_valid(req2_valid), .imem_req_ready(ready2), .imem_req_addr(req2_addr),
    .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
    .instr_valid(iv2), .instruction_out(ins2), .pc_out(pc2));

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit stale; } out_t;
  typedef struct { bit halt; bit ev; logic [31:0] ea; bit iv; logic [31:0] pc; } vec_t;

  mreq_t       mq[$], mq2[$];
  out_t        out_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch;
  logic [31:0] a2q[$], p2q[$];
  int          n_cmp, n_bad, cyc, lat;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_ins;
  vec_t        vt[18];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic vec_t v(bit h, bit ev, logic [31:0] ea, bit iv, logic [31:0] pc);
    vec_t r;
    r.halt = h; r.ev = ev; r.ea = ea; r.iv = iv; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: outstanding requests (with wrong-path marks), buffered pcs, next fetch address.
  task automatic model_step();
    bit boot, exp_iv, stale_any;
    out_t f;
    boot   = (cyc == 0);
    exp_iv = (exp_q.size() > 0) && !boot;
    chk("instr_valid", 32'(s_iv), 32'(exp_iv));
    if (exp_iv) begin
      chk("pc_out", s_pc, exp_q[0]);
      chk("instruction_out", s_ins, mem_word(exp_q[0]));
    end else begin
      chk("nop_when_invalid", s_ins, NOP_INSTR);
    end
    stale_any = 1'b0;
    foreach (out_q[i]) if (out_q[i].stale) stale_any = 1'b1;
    if (boot || redirect_valid || stale_any || (out_q.size() + exp_q.size() >= D))
      chk("req_must_be_idle", 32'(s_rv), 32'd0);
    if (imem_rsp_valid && out_q.size() > 0) begin
      f = out_q.pop_front();
      if (!f.stale && !redirect_valid) exp_q.push_back(f.pc);
    end
    if (exp_iv && !halt && !redirect_valid) void'(exp_q.pop_front());
    if (s_rv && imem_req_ready) begin
      chk("req_addr", s_addr, exp_fetch);
      out_q.push_back('{pc: exp_fetch, stale: 1'b0});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      exp_fetch = redirect_pc & ~32'd3;
    end
  endtask

  task automatic cycle(input bit h, input bit r, input logic [31:0] rpc, input bit rdy);
    int due;
    halt = h; redirect_valid = r; redirect_pc = rpc; imem_req_ready = rdy;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'hDEAD_BEEF;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mq[0].addr); void'(mq.pop_front());
    end
    rsp2_valid = 1'b0; rsp2_data = 32'hDEAD_BEEF;
    if (mq2.size() > 0 && mq2[0].due <= cyc) begin
      rsp2_valid = 1'b1; rsp2_data = mem_word(mq2[0].addr); void'(mq2.pop_front());
    end
    @(negedge clk);
    s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = instr_valid; s_pc = pc_out; s_ins = instruction_out;
    model_step();
    if (s_rv && rdy) begin
      due = cyc + lat;
      if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
      mq.push_back('{addr: s_addr, due: due});
    end
    if (req2_valid) begin
      mq2.push_back('{addr: req2_addr, due: cyc + 1});
      if (a2q.size() < 4) a2q.push_back(req2_addr);
    end
    if (iv2 && p2q.size() < 4) p2q.push_back(pc2);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; rsp2_valid = 1'b0; rsp2_data = '0;
    mq.delete(); mq2.delete(); out_q.delete(); exp_q.delete(); exp_fetch = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst.instr_valid", 32'(instr_valid), 32'd0);
    chk("rst.instruction", instruction_out, NOP_INSTR);
    chk("rst.pc_out", pc_out, 32'd0);
    chk("rst.wrap_req_valid", 32'(req2_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wexp [4];
    bit found;
    int pops;
    bit r;
    n_cmp = 0; n_bad = 0; cyc = 0; lat = 1;
    halt2 = 1'b0; redir2 = 1'b0; redir_pc2 = '0; ready2 = 1'b1;
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    // Streaming with a 1-cycle memory, then halt for 5 cycles with a full buffer.
    vt[0]  = v(0, 0, 32'h00, 0, 32'h00);
    vt[1]  = v(0, 1, 32'h00, 0, 32'h00);
    vt[2]  = v(0, 1, 32'h04, 0, 32'h00);
    vt[3]  = v(0, 0, 32'h00, 1, 32'h00);
    vt[4]  = v(0, 1, 32'h08, 1, 32'h04);
    vt[5]  = v(0, 1, 32'h0C, 0, 32'h00);
    vt[6]  = v(0, 0, 32'h00, 1, 32'h08);
    vt[7]  = v(0, 1, 32'h10, 1, 32'h0C);
    vt[8]  = v(0, 1, 32'h14, 0, 32'h00);
    vt[9]  = v(1, 0, 32'h00, 1, 32'h10);
    vt[10] = v(1, 0, 32'h00, 1, 32'h10);
    vt[11] = v(1, 0, 32'h00, 1, 32'h10);
    vt[12] = v(1, 0, 32'h00, 1, 32'h10);
    vt[13] = v(1, 0, 32'h00, 1, 32'h10);
    vt[14] = v(0, 0, 32'h00, 1, 32'h10);
    vt[15] = v(0, 1, 32'h18, 1, 32'h14);
    vt[16] = v(0, 1, 32'h1C, 0, 32'h00);
    vt[17] = v(0, 0, 32'h00, 1, 32'h18);

    lat = 1;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(vt[i].halt, 1'b0, 32'h0, 1'b1);
      chk($sformatf("vec%0d.req_valid", i), 32'(s_rv), 32'(vt[i].ev));
      if (vt[i].ev) chk($sformatf("vec%0d.req_addr", i), s_addr, vt[i].ea);
      chk($sformatf("vec%0d.instr_valid", i), 32'(s_iv), 32'(vt[i].iv));
      if (vt[i].iv) begin
        chk($sformatf("vec%0d.pc_out", i), s_pc, vt[i].pc);
        chk($sformatf("vec%0d.instr", i), s_ins, mem_word(vt[i].pc));
      end else begin
        chk($sformatf("vec%0d.nop", i), s_ins, NOP_INSTR);
      end
    end

    // PC wrap-around on the instance started at 0xFFFF_FFF8.
    chk("wrap.req_count", 32'(a2q.size()), 32'd4);
    chk("wrap.pc_count", 32'(p2q.size()), 32'd4);
    for (int i = 0; i < a2q.size() && i < 4; i++) chk($sformatf("wrap.req%0d", i), a2q[i], wexp[i]);
    for (int i = 0; i < p2q.size() && i < 4; i++) chk($sformatf("wrap.pc%0d", i), p2q[i], wexp[i]);

    // Redirect with two requests in flight: both stale words dropped.
    lat = 4;
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    chk("redir.req_gated", 32'(s_rv), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir.iv_next", 32'(s_iv), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (s_iv) begin
        found = 1'b1;
        chk("redir.first_pc", s_pc, 32'h0000_0100);
        chk("redir.first_instr", s_ins, mem_word(32'h0000_0100));
      end
    end
    chk("redir.seen_in_time", 32'(found), 32'd1);

    // Redirect coinciding with a response while halted.
    lat = 2;
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("halt_redir.req_gated", 32'(s_rv), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("halt_redir.iv_next", 32'(s_iv), 32'd0);
    chk("halt_redir.req_valid", 32'(s_rv), 32'd1);
    chk("halt_redir.req_addr", s_addr, 32'h0000_0200);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (s_iv) begin
        found = 1'b1;
        chk("halt_redir.first_pc", s_pc, 32'h0000_0200);
      end
    end
    chk("halt_redir.seen_in_time", 32'(found), 32'd1);

    // Randomised traffic against the reference model.
    do_reset();
    pops = 0;
    for (int k = 0; k < 3000; k++) begin
      lat = $urandom_range(1, 4);
      r = ($urandom_range(0, 99) < 3);
      cycle(($urandom_range(0, 99) < 30), r, $urandom & 32'h0000_FFFF, ($urandom_range(0, 99) < 70));
      if (s_iv && !halt && !r) pops++;
    end
    n_cmp++;
    if (pops < 200) begin
      n_bad++;
      $display("FAIL rand.progress: got %0d instructions consumed, required at least 200", pops);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
